// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe
// ------------
// Pipelined RV32I/RV64I immediate generator with a 2-entry (out + skid)
// elastic buffer. It decodes the I/S/B/U/J immediate of each accepted
// instruction, sign-extends it to XLEN and registers it with the format code,
// an illegal-opcode flag and the instruction's PC. Latency is one cycle.
//
// Optional feature (compile-time macro IMM_GEN_PC_TARGET_EN):
//   When defined, adds out_target = (pc + imm) mod 2^PC_W for branches, JAL
//   and AUIPC, and 0 for every other entry. JALR is excluded because its
//   base is rs1. When undefined, the port and the adder do not exist.
//
// Handshake semantics (both interfaces): a transfer happens on a rising edge
// where valid and ready are both 1. A producer holds valid and its payload
// steady until the transfer happens. in_ready is a register (it equals
// !skid_valid), so it never depends combinationally on out_ready.
// out_* hold still while out_valid=1 and out_ready=0.
//
// Ports:
//   clk, rst     clock; asynchronous active-high reset
//   flush        synchronous discard of both buffered entries and of any
//                same-edge accept; takes priority over all handshakes
//   in_valid     upstream offers in_instr/in_pc
//   in_ready     block can take an instruction this cycle
//   in_instr     32-bit instruction word
//   in_pc        PC of in_instr (PC_W bits), passed through unchanged
//   out_valid    out_* hold a valid entry
//   out_ready    downstream accepts the entry on out_*
//   out_imm      decoded immediate, sign-extended to XLEN
//   out_fmt      0=NONE 1=I 2=S 3=B 4=U 5=J
//   out_illegal  opcode is neither immediate-carrying nor a known non-imm op
//   out_pc       PC of the entry on out_*
//   out_target   (macro only) branch/jump/AUIPC target
//
// Parameters: XLEN (32 or 64), PC_W (defaults to XLEN).

module imm_gen_pipe #(
    parameter int XLEN = 32,
    parameter int PC_W = XLEN
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [PC_W-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_fmt,
    output logic            out_illegal,
    output logic [PC_W-1:0] out_pc
`ifdef IMM_GEN_PC_TARGET_EN
    ,
    output logic [PC_W-1:0] out_target
`endif
);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_REG32  = 7'b0111011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [2:0] FMT_NONE = 3'd0;
    localparam logic [2:0] FMT_I    = 3'd1;
    localparam logic [2:0] FMT_S    = 3'd2;
    localparam logic [2:0] FMT_B    = 3'd3;
    localparam logic [2:0] FMT_U    = 3'd4;
    localparam logic [2:0] FMT_J    = 3'd5;

    // ------------------------------------------------------------------
    // Combinational decode of the incoming instruction
    // ------------------------------------------------------------------
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [XLEN-1:0] dec_imm;
    logic [2:0]      dec_fmt;
    logic            dec_illegal;
    logic [XLEN-1:0] shamt;

    assign opcode = in_instr[6:0];
    assign funct3 = in_instr[14:12];

    // Shift amount is 5 bits on RV32 and 6 bits on RV64; bit 30 (the SRAI
    // marker) is never part of the immediate.
    assign shamt = (XLEN == 32) ? {{(XLEN-5){1'b0}}, in_instr[24:20]}
                                : {{(XLEN-6){1'b0}}, in_instr[25:20]};

    always_comb begin
        dec_imm     = '0;
        dec_fmt     = FMT_NONE;
        dec_illegal = 1'b0;
        case (opcode)
            OP_LOAD, OP_JALR: begin
                dec_fmt = FMT_I;
                dec_imm = {{(XLEN-12){in_instr[31]}}, in_instr[31:20]};
            end
            OP_IMM: begin
                dec_fmt = FMT_I;
                if (funct3 == 3'b001 || funct3 == 3'b101) begin
                    dec_imm = shamt;
                end else begin
                    dec_imm = {{(XLEN-12){in_instr[31]}}, in_instr[31:20]};
                end
            end
            OP_STORE: begin
                dec_fmt = FMT_S;
                dec_imm = {{(XLEN-12){in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
            end
            OP_BRANCH: begin
                dec_fmt = FMT_B;
                dec_imm = {{(XLEN-12){in_instr[31]}}, in_instr[7], in_instr[30:25],
                           in_instr[11:8], 1'b0};
            end
            OP_LUI, OP_AUIPC: begin
                dec_fmt = FMT_U;
                // Bit 31 is the sign; the replication covers it plus any
                // RV64 upper half.
                dec_imm = {{(XLEN-31){in_instr[31]}}, in_instr[30:12], 12'b0};
            end
            OP_JAL: begin
                dec_fmt = FMT_J;
                dec_imm = {{(XLEN-20){in_instr[31]}}, in_instr[19:12], in_instr[20],
                           in_instr[30:21], 1'b0};
            end
            default: begin
                // Known opcodes without an immediate are legal, all else is not.
                dec_illegal = !(opcode == OP_REG   || opcode == OP_REG32 ||
                                opcode == OP_FENCE || opcode == OP_SYSTEM);
            end
        endcase
    end

`ifdef IMM_GEN_PC_TARGET_EN
    logic [PC_W-1:0] imm_pcw;
    logic [PC_W-1:0] dec_target;
    logic [PC_W-1:0] skid_target;

    // Resize the immediate to the PC width (truncate or sign-extend).
    if (PC_W <= XLEN) begin : g_imm_trunc
        assign imm_pcw = dec_imm[PC_W-1:0];
    end else begin : g_imm_sext
        assign imm_pcw = {{(PC_W-XLEN){dec_imm[XLEN-1]}}, dec_imm};
    end

    assign dec_target = (dec_fmt == FMT_B || dec_fmt == FMT_J || opcode == OP_AUIPC)
                        ? (in_pc + imm_pcw) : '0;
`endif

    // ------------------------------------------------------------------
    // Output stage plus one skid entry. The skid only fills when out is
    // stalled, so skid_valid implies out_valid and order stays FIFO.
    // ------------------------------------------------------------------
    logic            skid_valid;
    logic [XLEN-1:0] skid_imm;
    logic [2:0]      skid_fmt;
    logic            skid_illegal;
    logic [PC_W-1:0] skid_pc;
    logic            accept;
    logic            out_free;

    assign in_ready = ~skid_valid;
    assign accept   = in_valid & in_ready;
    assign out_free = ~out_valid | out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid    <= 1'b0;
            out_imm      <= '0;
            out_fmt      <= FMT_NONE;
            out_illegal  <= 1'b0;
            out_pc       <= '0;
            skid_valid   <= 1'b0;
            skid_imm     <= '0;
            skid_fmt     <= FMT_NONE;
            skid_illegal <= 1'b0;
            skid_pc      <= '0;
`ifdef IMM_GEN_PC_TARGET_EN
            out_target   <= '0;
            skid_target  <= '0;
`endif
        end else if (flush) begin
            // Drop everything, including an accept on this same edge.
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
        end else if (out_free) begin
            if (skid_valid) begin
                // in_ready is low while the skid is full, so no accept can
                // compete with this refill.
                out_valid   <= 1'b1;
                out_imm     <= skid_imm;
                out_fmt     <= skid_fmt;
                out_illegal <= skid_illegal;
                out_pc      <= skid_pc;
`ifdef IMM_GEN_PC_TARGET_EN
                out_target  <= skid_target;
`endif
                skid_valid  <= 1'b0;
            end else if (accept) begin
                out_valid   <= 1'b1;
                out_imm     <= dec_imm;
                out_fmt     <= dec_fmt;
                out_illegal <= dec_illegal;
                out_pc      <= in_pc;
`ifdef IMM_GEN_PC_TARGET_EN
                out_target  <= dec_target;
`endif
            end else begin
                out_valid <= 1'b0;
            end
        end else if (accept) begin
            // Out is stalled: park the new entry in the skid.
            skid_valid   <= 1'b1;
            skid_imm     <= dec_imm;
            skid_fmt     <= dec_fmt;
            skid_illegal <= dec_illegal;
            skid_pc      <= in_pc;
`ifdef IMM_GEN_PC_TARGET_EN
            skid_target  <= dec_target;
`endif
        end
    end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Testbench for imm_gen_pipe. Two instances (XLEN=32 and XLEN=64/PC_W=64)
// share the same stimulus. A reference model computes the immediates
// arithmetically from the instruction fields and tracks the buffer as a
// capacity-2 FIFO. A compare process checks both DUTs on every falling edge.
// Directed vectors also carry hand-computed literal expectations.

module tb_imm_gen_pipe;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic        flush, in_valid, out_ready;
    logic [31:0] in_instr, in_pc;
    logic [63:0] in_pc64;
    assign in_pc64 = {32'h0, in_pc};

    logic        in_ready32, out_valid32, out_illegal32;
    logic [31:0] out_imm32, out_pc32;
    logic [2:0]  out_fmt32;
    logic        in_ready64, out_valid64, out_illegal64;
    logic [63:0] out_imm64, out_pc64;
    logic [2:0]  out_fmt64;
`ifdef IMM_GEN_PC_TARGET_EN
    logic [31:0] out_target32;
    logic [63:0] out_target64;
`endif

    imm_gen_pipe #(.XLEN(32), .PC_W(32)) u_dut32 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready32),
        .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(out_valid32), .out_ready(out_ready),
        .out_imm(out_imm32), .out_fmt(out_fmt32),
        .out_illegal(out_illegal32), .out_pc(out_pc32)
`ifdef IMM_GEN_PC_TARGET_EN
        , .out_target(out_target32)
`endif
    );

    imm_gen_pipe #(.XLEN(64), .PC_W(64)) u_dut64 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready64),
        .in_instr(in_instr), .in_pc(in_pc64),
        .out_valid(out_valid64), .out_ready(out_ready),
        .out_imm(out_imm64), .out_fmt(out_fmt64),
        .out_illegal(out_illegal64), .out_pc(out_pc64)
`ifdef IMM_GEN_PC_TARGET_EN
        , .out_target(out_target64)
`endif
    );

    // ---------------- checking helpers ----------------
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [31:0] imm32;
        logic [63:0] imm64;
        logic [2:0]  fmt;
        logic        ill;
        logic [31:0] pc;
        logic [31:0] tgt32;
        logic [63:0] tgt64;
    } exp_t;

    exp_t exp_q[$];

    // Sign-extend the low n bits of v (upper bits of v are zero).
    function automatic logic [63:0] sx(input logic [63:0] v, input int n);
        return v[n-1] ? (v - (64'd1 << n)) : v;
    endfunction

    function automatic exp_t model(input logic [31:0] instr, input logic [31:0] pc);
        exp_t e;
        logic [63:0] v;
        logic [63:0] i_val;
        e = '0;
        e.pc = pc;
        i_val = sx(64'(instr[31:20]), 12);
        case (instr[6:0])
            7'h03, 7'h67: begin e.fmt = 3'd1; e.imm64 = i_val; e.imm32 = i_val[31:0]; end
            7'h13: begin
                e.fmt = 3'd1;
                if (instr[14:12] == 3'd1 || instr[14:12] == 3'd5) begin
                    e.imm64 = 64'(instr[25:20]);
                    e.imm32 = 32'(instr[24:20]);
                end else begin
                    e.imm64 = i_val;
                    e.imm32 = i_val[31:0];
                end
            end
            7'h23: begin
                e.fmt = 3'd2;
                v = 64'(instr[31:25]) * 32 + 64'(instr[11:7]);
                e.imm64 = sx(v, 12); e.imm32 = e.imm64[31:0];
            end
            7'h63: begin
                e.fmt = 3'd3;
                v = 64'(instr[31]) * 4096 + 64'(instr[7]) * 2048
                  + 64'(instr[30:25]) * 32 + 64'(instr[11:8]) * 2;
                e.imm64 = sx(v, 13); e.imm32 = e.imm64[31:0];
            end
            7'h37, 7'h17: begin
                e.fmt = 3'd4;
                v = 64'(instr[31:12]) * 4096;
                e.imm64 = sx(v, 32); e.imm32 = e.imm64[31:0];
            end
            7'h6F: begin
                e.fmt = 3'd5;
                v = 64'(instr[31]) * (64'd1 << 20) + 64'(instr[19:12]) * 4096
                  + 64'(instr[20]) * 2048 + 64'(instr[30:21]) * 2;
                e.imm64 = sx(v, 21); e.imm32 = e.imm64[31:0];
            end
            7'h33, 7'h3B, 7'h0F, 7'h73: e.ill = 1'b0;
            default: e.ill = 1'b1;
        endcase
        if (e.fmt == 3'd3 || e.fmt == 3'd5 || instr[6:0] == 7'h17) begin
            e.tgt64 = {32'h0, pc} + e.imm64;
            e.tgt32 = pc + e.imm32;
        end
        return e;
    endfunction

    // FIFO of capacity two: ready while fewer than two entries are held.
    always @(posedge clk or posedge rst) begin
        if (rst || flush) begin
            exp_q.delete();
        end else begin
            int  sz;
            exp_t e;
            sz = exp_q.size();
            e  = model(in_instr, in_pc);
            if (sz > 0 && out_ready) void'(exp_q.pop_front());
            if (in_valid && sz < 2) exp_q.push_back(e);
        end
    end

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        check("in_ready32", 64'(in_ready32), 64'(exp_q.size() < 2));
        check("in_ready64", 64'(in_ready64), 64'(exp_q.size() < 2));
        check("out_valid32", 64'(out_valid32), 64'(exp_q.size() > 0));
        check("out_valid64", 64'(out_valid64), 64'(exp_q.size() > 0));
        if (exp_q.size() > 0) begin
            check("sb_imm32", 64'(out_imm32), 64'(exp_q[0].imm32));
            check("sb_imm64", out_imm64, exp_q[0].imm64);
            check("sb_fmt32", 64'(out_fmt32), 64'(exp_q[0].fmt));
            check("sb_fmt64", 64'(out_fmt64), 64'(exp_q[0].fmt));
            check("sb_ill32", 64'(out_illegal32), 64'(exp_q[0].ill));
            check("sb_ill64", 64'(out_illegal64), 64'(exp_q[0].ill));
            check("sb_pc32", 64'(out_pc32), 64'(exp_q[0].pc));
            check("sb_pc64", out_pc64, 64'(exp_q[0].pc));
`ifdef IMM_GEN_PC_TARGET_EN
            check("sb_tgt32", 64'(out_target32), 64'(exp_q[0].tgt32));
            check("sb_tgt64", out_target64, exp_q[0].tgt64);
`endif
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive(input logic v, input logic [31:0] instr, input logic [31:0] pc);
        in_valid = v;
        in_instr = instr;
        in_pc    = pc;
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // ---------------- directed vector table ----------------
    localparam int NV = 16;
    logic [31:0] t_instr [NV];
    logic [31:0] t_pc    [NV];
    logic [31:0] t_imm32 [NV];
    logic [63:0] t_imm64 [NV];
    logic [2:0]  t_fmt   [NV];
    logic        t_ill   [NV];
    logic [63:0] t_tgt   [NV];

    initial begin
        t_instr = '{32'hFFF00093, 32'h4030D093, 32'hFE20AE23, 32'h0010006F,
                    32'h800002B7, 32'h0000007F, 32'h002081B3, 32'hFE000EE3,
                    32'h00001517, 32'h00408067, 32'h02009093, 32'h80002083,
                    32'h0000000F, 32'h00000073, 32'h0000001B, 32'hFFFFF517};
        t_pc    = '{32'h0, 32'h10, 32'h20, 32'h100, 32'h40, 32'h44, 32'h48, 32'h200,
                    32'h400, 32'h300, 32'h50, 32'h54, 32'h58, 32'h5C, 32'h60, 32'h2000};
        t_imm32 = '{32'hFFFFFFFF, 32'h3, 32'hFFFFFFFC, 32'h800, 32'h80000000, 32'h0,
                    32'h0, 32'hFFFFFFFC, 32'h1000, 32'h4, 32'h0, 32'hFFFFF800,
                    32'h0, 32'h0, 32'h0, 32'hFFFFF000};
        t_imm64 = '{64'hFFFFFFFFFFFFFFFF, 64'h3, 64'hFFFFFFFFFFFFFFFC, 64'h800,
                    64'hFFFFFFFF80000000, 64'h0, 64'h0, 64'hFFFFFFFFFFFFFFFC,
                    64'h1000, 64'h4, 64'h20, 64'hFFFFFFFFFFFFF800,
                    64'h0, 64'h0, 64'h0, 64'hFFFFFFFFFFFFF000};
        t_fmt   = '{3'd1, 3'd1, 3'd2, 3'd5, 3'd4, 3'd0, 3'd0, 3'd3,
                    3'd4, 3'd1, 3'd1, 3'd1, 3'd0, 3'd0, 3'd0, 3'd4};
        t_ill   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0,
                    1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        t_tgt   = '{64'h0, 64'h0, 64'h0, 64'h900, 64'h0, 64'h0, 64'h0, 64'h1FC,
                    64'h1400, 64'h0, 64'h0, 64'h0, 64'h0, 64'h0, 64'h0, 64'h1000};
    end

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // ---------------- main sequence ----------------
    localparam logic [31:0] A_I = 32'hFFF00093;  // imm 0xFFFFFFFF
    localparam logic [31:0] B_I = 32'hFE20AE23;  // imm 0xFFFFFFFC
    localparam logic [31:0] C_I = 32'h0010006F;  // imm 0x800

    initial begin
        exp_t m;
        rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
        drive(1'b0, 32'h0, 32'h0);
        #2;
        check("rst_out_valid", 64'(out_valid32), 64'd0);
        check("rst_in_ready", 64'(in_ready32), 64'd1);
        check("rst_imm32", 64'(out_imm32), 64'd0);
        check("rst_imm64", out_imm64, 64'd0);
        check("rst_fmt", 64'(out_fmt32), 64'd0);
        check("rst_ill", 64'(out_illegal32), 64'd0);
        check("rst_pc", 64'(out_pc32), 64'd0);
`ifdef IMM_GEN_PC_TARGET_EN
        check("rst_tgt", 64'(out_target32), 64'd0);
`endif
        tick(); tick();
        rst = 1'b0;
        tick();
        check("ready_after_rst", 64'(in_ready32), 64'd1);

        // Directed decode vectors, streamed at full rate.
        out_ready = 1'b1;
        for (int i = 0; i < NV; i++) begin
            drive(1'b1, t_instr[i], t_pc[i]);
            m = model(t_instr[i], t_pc[i]);
            check("model_imm64", m.imm64, t_imm64[i]);
            check("model_imm32", 64'(m.imm32), 64'(t_imm32[i]));
            check("model_tgt", m.tgt64, t_tgt[i]);
            check("model_tgt32", 64'(m.tgt32), 64'(t_tgt[i][31:0]));
            tick();
            check("vec_imm32", 64'(out_imm32), 64'(t_imm32[i]));
            check("vec_imm64", out_imm64, t_imm64[i]);
            check("vec_fmt", 64'(out_fmt32), 64'(t_fmt[i]));
            check("vec_ill", 64'(out_illegal64), 64'(t_ill[i]));
`ifdef IMM_GEN_PC_TARGET_EN
            check("vec_tgt32", 64'(out_target32), 64'(t_tgt[i][31:0]));
            check("vec_tgt64", out_target64, t_tgt[i]);
`endif
        end
        drive(1'b0, 32'h0, 32'h0);
        tick();
        check("drain_idle", 64'(out_valid32), 64'd0);

        // Backpressure: A to out, B to skid, C held upstream.
        out_ready = 1'b0;
        drive(1'b1, A_I, 32'h1000); tick();
        check("bp_a_out", 64'(out_imm32), 64'hFFFFFFFF);
        drive(1'b1, B_I, 32'h1004); tick();
        check("bp_ready_low", 64'(in_ready32), 64'd0);
        drive(1'b1, C_I, 32'h1008); tick();
        check("bp_a_stable", 64'(out_pc32), 64'h1000);
        check("bp_ready_low2", 64'(in_ready64), 64'd0);
        out_ready = 1'b1; tick();
        check("bp_b_out", 64'(out_imm32), 64'hFFFFFFFC);
        check("bp_ready_back", 64'(in_ready32), 64'd1);
        tick();
        check("bp_c_out", 64'(out_imm32), 64'h800);
        check("bp_c_pc", 64'(out_pc32), 64'h1008);
        drive(1'b0, 32'h0, 32'h0); tick();
        check("bp_empty", 64'(out_valid32), 64'd0);

        // Flush with both stages full and a same-edge input.
        out_ready = 1'b0;
        drive(1'b1, A_I, 32'h2000); tick();
        drive(1'b1, B_I, 32'h2004); tick();
        drive(1'b1, C_I, 32'h2008); flush = 1'b1; tick();
        flush = 1'b0; drive(1'b0, 32'h0, 32'h0);
        check("fl_valid", 64'(out_valid32), 64'd0);
        check("fl_ready", 64'(in_ready32), 64'd1);
        tick();
        check("fl_stays_empty", 64'(out_valid64), 64'd0);

        // Flush while an accept would otherwise succeed.
        drive(1'b1, A_I, 32'h2100); tick();
        drive(1'b1, B_I, 32'h2104); flush = 1'b1; tick();
        flush = 1'b0; drive(1'b0, 32'h0, 32'h0);
        check("fl_accept_drop", 64'(out_valid32), 64'd0);
        out_ready = 1'b1;
        drive(1'b1, C_I, 32'h2200); tick();
        check("fl_next_imm", 64'(out_imm32), 64'h800);
        check("fl_next_pc", 64'(out_pc32), 64'h2200);
        drive(1'b0, 32'h0, 32'h0); tick();

        // Asynchronous reset between edges while an entry is held.
        out_ready = 1'b0;
        drive(1'b1, B_I, 32'h3000); tick();
        drive(1'b0, 32'h0, 32'h0);
        check("ar_before", 64'(out_valid32), 64'd1);
        #2 rst = 1'b1;
        #1;
        check("ar_valid", 64'(out_valid32), 64'd0);
        check("ar_imm", 64'(out_imm32), 64'd0);
        check("ar_fmt", 64'(out_fmt64), 64'd0);
        check("ar_imm64", out_imm64, 64'd0);
        tick();
        rst = 1'b0;
        out_ready = 1'b1;
        drive(1'b1, C_I, 32'h3100); tick();
        check("ar_first_push", 64'(out_imm32), 64'h800);
        check("ar_first_valid", 64'(out_valid32), 64'd1);
        drive(1'b0, 32'h0, 32'h0); tick();
        check("ar_done", 64'(out_valid32), 64'd0);

        tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
Parametrised, pipelined successor to the combinational immediate generator. It decodes the immediate for every RV32I/RV64I base format (I, S, B, U, J) from a 32-bit instruction word, sign-extended to XLEN. The block sits between fetch/decode and execute. It has a valid/ready handshake and a 2-entry skid buffer, so full throughput is kept under backpressure. It also reports the decoded format and an illegal-opcode flag, and supports a pipeline flush.

Parameters:
XLEN, 32, datapath width; legal values are 32 or 64. Sign extension fills bits XLEN-1..32 when XLEN=64.
PC_W, XLEN, width of the PC sideband carried alongside each instruction.

Ports:
clk  input  1  single clock; all state updates on the rising edge
rst  input  1  reset; asynchronous, active-high
flush  input  1  synchronous discard of all buffered entries
in_valid  input  1  upstream has an instruction
in_ready  output  1  block can accept; registered, equals !skid_valid
in_instr  input  32  instruction word
in_pc  input  PC_W  PC of in_instr, passed through unchanged
out_valid  output  1  out_* fields hold a valid entry
out_ready  input  1  downstream accepts
out_imm  output  XLEN  decoded, sign-extended immediate
out_fmt  output  3  0=NONE 1=I 2=S 3=B 4=U 5=J
out_illegal  output  1  opcode is not a recognised immediate-carrying opcode
out_pc  output  PC_W  PC of the entry on out_*
out_target  output  PC_W  out_pc+out_imm; present only with IMM_GEN_PC_TARGET_EN

Behaviour:
- Reset (asynchronous, rst=1):
  - out_valid=0 and skid_valid=0.
  - All data outputs (out_imm, out_fmt, out_pc, out_illegal, out_target) = 0.
  - in_ready=1, both during reset and on the first edge after it.
- Decode by in_instr[6:0]:
  - 0000011 (load), 0010011 (OP-IMM), 1100111 (JALR) → I: imm = sext(instr[31:20]).
  - OP-IMM with funct3 001 or 101 (shifts) → I: imm = zero-extended shamt, using instr[24:20] if XLEN=32 or instr[25:20] if XLEN=64. instr[30] (SRAI marker) is excluded from imm.
  - 0100011 → S: sext({instr[31:25], instr[11:7]}).
  - 1100011 → B: sext({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}).
  - 0110111 (LUI), 0010111 (AUIPC) → U: sext({instr[31:12], 12'b0}).
  - 1101111 → J: sext({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}).
  - Any other opcode (including R-type) → fmt=NONE, imm=0, illegal=1 only if the opcode is also not 0110011/0111011/0001111/1110011; otherwise illegal=0.
- Latency: exactly 1 cycle. Accept at edge N (in_valid & in_ready) → out_valid=1 after edge N, if the output stage was free.
- Output stage (out) plus skid stage:
  - Accept while out is empty or draining (out_ready=1) → decoded result goes to out.
  - Accept while out_valid=1 and out_ready=0 → decoded result goes to skid; in_ready drops after that edge.
  - Out pops (out_valid & out_ready) with skid full → skid moves to out, skid empties, in_ready returns to 1 on the next cycle.
- Order is strictly FIFO. There is no bypass and no duplication. Outputs are stable while out_valid=1 and out_ready=0.
- Simultaneous pop and push with skid empty → new entry replaces out; out_valid stays 1.
- flush=1 at an edge:
  - out_valid=0 and skid_valid=0.
  - Any same-cycle accept is discarded.
  - in_ready=1 from the next cycle.
  - flush has priority over all handshakes.
- An async rst mid-transfer drops all entries immediately. Downstream must not count an in-flight pop on that edge.

Optional Feature:
Macro IMM_GEN_PC_TARGET_EN.
- Defined: an out_target port exists and is registered with the entry. Value is (pc + imm) modulo 2^PC_W for fmt B, J and AUIPC; 0 otherwise (including JALR, whose base is rs1). Reset value 0.
- Undefined: the port and adder are absent. All other behaviour is identical.

Test Plan:
- XLEN=32: push 0xFFF00093 (addi x1,x0,-1) → next cycle out_imm=0xFFFFFFFF, fmt=1, illegal=0. Then push 0x4030D093 (srai x1,x1,3) → out_imm=0x00000003.
- Push 0xFE20AE23 (sw -4) → out_imm=0xFFFFFFFC, fmt=2. Push 0x0010006F (jal +2048) with in_pc=0x100 → out_imm=0x00000800, fmt=5; with the macro, out_target=0x900.
- XLEN=64: push 0x800002B7 (lui x5,0x80000) → out_imm=0xFFFFFFFF80000000, fmt=4. Push 0x0000007F → fmt=0, imm=0, illegal=1.
- Backpressure: hold out_ready=0 and push A, B, C back-to-back. A appears on out; B is in skid; in_ready=0 and C is held upstream. Raise out_ready → A, B, C emerge in order, one per cycle, with no gaps.
- Pulse flush with out and skid both full, and in_valid=1 on the same edge → out_valid=0 next cycle, in_ready=1, the flushed entries never appear, and the same-cycle input is dropped.
- Assert rst asynchronously between edges while out_valid=1 → out_valid, out_imm and out_fmt go to 0 immediately. After release, the first push appears after 1 cycle.
